// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: key-schedule state encoding, round constants,
// and the word-level helpers used by key expansion.
package aes128_pkg;

   localparam int NR       = 10;
   localparam int RK_DEPTH = NR + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_READY  = 2'd2
   } ks_state_t;

   // Round constants for rounds 1..10; element 9 is round 1.
   localparam logic [9:0][7:0] RCON = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon_at(input logic [3:0] round);
      if (round >= 4'd1 && round <= 4'd10) begin
         return RCON[4'd10 - round];
      end
      return 8'h00;
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // One round of the schedule given SubWord(RotWord(w3)) already computed.
   function automatic logic [127:0] key_step(input logic [127:0] prev,
                                             input logic [31:0]  sub_rot,
                                             input logic [7:0]   rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = prev[127:96] ^ sub_rot ^ {rc, 24'h0};
      w1 = prev[95:64] ^ w0;
      w2 = prev[63:32] ^ w1;
      w3 = prev[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational lookup.
module aes_sbox (
   input  logic [7:0] value,
   output logic [7:0] subst
);

   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the top byte, so the bit offset is 8*(255-value) = {~value,000}.
   logic [10:0] base;
   assign base  = {~value, 3'b000};
   assign subst = SBOX_TABLE[base +: 8];

endmodule

// File: rtl/aes128_key_sched.sv
// Iterative AES-128 key expansion: one round key per clock, all eleven kept
// in a register file so the cipher core can walk them in either direction.
module aes128_key_sched #(
   parameter int NR     = aes128_pkg::NR,
   parameter int RD_REG = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_load,
   output logic         busy,
   output logic         key_ready,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_out
);

   import aes128_pkg::*;

   ks_state_t    state;
   logic [3:0]   ctr;
   logic [7:0]   rcon;
   logic [127:0] rk [NR+1];

   logic [127:0] prev_key;
   logic [31:0]  rot;
   logic [31:0]  sub;
   logic [127:0] next_key;
   logic [127:0] rd_key;

   // Select the previously generated round key as the expansion source.
   always_comb begin
      prev_key = '0;
      if (ctr != 4'd0 && ctr <= 4'(NR)) begin
         prev_key = rk[ctr - 4'd1];
      end
   end

   assign rot = rot_word(prev_key[31:0]);

   for (genvar b = 0; b < 4; b++) begin : g_subword
      aes_sbox u_sbox (
         .value (rot[8*b +: 8]),
         .subst (sub[8*b +: 8])
      );
   end

   assign next_key = key_step(prev_key, sub, rcon);

   // Control FSM, round counter, rcon register and round-key storage.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         key_ready <= 1'b0;
         ctr       <= 4'd0;
         rcon      <= 8'h01;
         for (int i = 0; i <= NR; i++) begin
            rk[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE, ST_READY: begin
               if (key_load) begin
                  rk[0]     <= key_in;
                  ctr       <= 4'd1;
                  rcon      <= 8'h01;
                  state     <= ST_EXPAND;
                  busy      <= 1'b1;
                  key_ready <= 1'b0;
               end
            end
            ST_EXPAND: begin
               rk[ctr] <= next_key;
               ctr     <= ctr + 4'd1;
               rcon    <= xtime(rcon);
               if (ctr == 4'(NR)) begin
                  state     <= ST_READY;
                  busy      <= 1'b0;
                  key_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               busy      <= 1'b0;
               key_ready <= 1'b0;
            end
         endcase
      end
   end

   // Read mux; indices past the last round key return zero.
   always_comb begin
      rd_key = '0;
      if (rk_idx <= 4'(NR)) begin
         rd_key = rk[rk_idx];
      end
   end

   if (RD_REG != 0) begin : g_rd_reg
      // Registered read port: one edge of latency from rk_idx to rk_out.
      always_ff @(posedge clk) begin
         if (!rst) begin
            rk_out <= '0;
         end else begin
            rk_out <= rd_key;
         end
      end
   end else begin : g_rd_comb
      assign rk_out = rd_key;
   end

endmodule

// File: tb/tb_aes128_key_sched.sv
// Self-checking bench for aes128_key_sched: vector table plus directed
// timing, abort and read-port sequences against a FIPS-197 reference model.
module tb_aes128_key_sched;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] SEQ_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] SEQ_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic         clk;
   logic         rst;
   logic [127:0] key_in;
   logic         key_load;
   logic         busy;
   logic         key_ready;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;

   int num_compared;
   int num_mismatched;

   logic [7:0]   model_sbox [256];
   logic [127:0] model_rk [11];

   typedef struct {
      string        name;
      logic [127:0] key;
      logic [3:0]   idx;
      logic [127:0] expected;
   } vec_t;

   vec_t vecs[$];

   aes128_key_sched #(.NR(10), .RD_REG(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .key_load  (key_load),
      .busy      (busy),
      .key_ready (key_ready),
      .rk_idx    (rk_idx),
      .rk_out    (rk_out)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // S-box derived from first principles: multiplicative inverse then affine map.
   function automatic logic [7:0] sbox_of(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h00;
      if (a != 8'h00) begin
         for (int x = 1; x < 256; x++) begin
            if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
         end
      end
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   // Textbook word-array key expansion into model_rk.
   task automatic modelExpand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {model_sbox[t[23:16]], model_sbox[t[15:8]], model_sbox[t[7:0]], model_sbox[t[31:24]]}
                ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      num_compared++;
      if (actual !== expected) begin
         num_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Pulse key_load for exactly one edge; returns #1 after that edge.
   task automatic applyStimulus(input logic [127:0] key);
      key_in = key;
      key_load = 1'b1;
      @(posedge clk);
      #1;
      key_load = 1'b0;
   endtask

   // Count edges until key_ready, bounded; -1 on timeout.
   task automatic waitReady(output int n);
      n = 0;
      while (!key_ready && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!key_ready) n = -1;
   endtask

   task automatic readKey(input logic [3:0] idx, output logic [127:0] data);
      rk_idx = idx;
      @(posedge clk);
      #1;
      data = rk_out;
   endtask

   initial begin
      int           n;
      int           bad;
      logic [127:0] data;
      logic [127:0] rkey;

      num_compared = 0;
      num_mismatched = 0;
      rst = 1'b0;
      key_load = 1'b0;
      key_in = '0;
      rk_idx = 4'd0;

      for (int i = 0; i < 256; i++) model_sbox[i] = sbox_of(8'(i));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", 128'(busy), 128'(0));
      checkOutput("reset_key_ready", 128'(key_ready), 128'(0));
      checkOutput("reset_rk_out", rk_out, '0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Vector table: FIPS-197 constants plus random keys against the model
      vecs.push_back('{"fips_rk0", FIPS_KEY, 4'd0, FIPS_KEY});
      vecs.push_back('{"fips_rk1", FIPS_KEY, 4'd1, FIPS_RK1});
      vecs.push_back('{"fips_rk10", FIPS_KEY, 4'd10, FIPS_RK10});
      vecs.push_back('{"seq_rk10", SEQ_KEY, 4'd10, SEQ_RK10});
      for (int v = 0; v < 4; v++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom};
         modelExpand(rkey);
         for (int k = 0; k < 3; k++) begin
            n = $urandom_range(0, 10);
            vecs.push_back('{$sformatf("rand%0d_rk%0d", v, n), rkey, 4'(n), model_rk[n]});
         end
      end
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].key);
         waitReady(n);
         checkOutput({vecs[i].name, "_latency"}, 128'(n), 128'(10));
         readKey(vecs[i].idx, data);
         checkOutput(vecs[i].name, data, vecs[i].expected);
      end

      // Model self-consistency against the published FIPS-197 schedule
      modelExpand(FIPS_KEY);
      checkOutput("model_fips_rk10", model_rk[10], FIPS_RK10);

      // Timing window and registered read latency
      applyStimulus(FIPS_KEY);
      checkOutput("busy_at_E", 128'(busy), 128'(1));
      checkOutput("ready_low_at_E", 128'(key_ready), 128'(0));
      bad = 0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         if (busy !== 1'b1 || key_ready !== 1'b0) bad++;
      end
      checkOutput("busy_window", 128'(bad), 128'(0));
      @(posedge clk);
      #1;
      checkOutput("ready_at_E10", 128'(key_ready), 128'(1));
      checkOutput("busy_clear_E10", 128'(busy), 128'(0));
      readKey(4'd0, data);
      rk_idx = 4'd5;
      #1;
      checkOutput("rd_latency_before", rk_out, FIPS_KEY);
      @(posedge clk);
      #1;
      checkOutput("rd_latency_after", rk_out, model_rk[5]);

      // key_load during EXPAND is ignored
      applyStimulus(FIPS_KEY);
      repeat (3) @(posedge clk);
      #1;
      key_in = SEQ_KEY;
      key_load = 1'b1;
      @(posedge clk);
      #1;
      key_load = 1'b0;
      waitReady(n);
      checkOutput("midload_latency", 128'(n), 128'(6));
      readKey(4'd10, data);
      checkOutput("midload_rk10", data, FIPS_RK10);

      // Reload from READY
      applyStimulus(SEQ_KEY);
      checkOutput("reload_ready_drop", 128'(key_ready), 128'(0));
      checkOutput("reload_busy", 128'(busy), 128'(1));
      waitReady(n);
      checkOutput("reload_latency", 128'(n), 128'(10));
      readKey(4'd10, data);
      checkOutput("reload_rk10", data, SEQ_RK10);

      // Out-of-range indices and descending sweep
      applyStimulus(FIPS_KEY);
      waitReady(n);
      checkOutput("sweep_latency", 128'(n), 128'(10));
      readKey(4'd11, data);
      checkOutput("idx11_zero", data, '0);
      readKey(4'd15, data);
      checkOutput("idx15_zero", data, '0);
      for (int r = 10; r >= 0; r--) begin
         readKey(4'(r), data);
         checkOutput($sformatf("sweep_rk%0d", r), data, model_rk[r]);
      end

      // Reset abort mid-expansion at ctr==4
      applyStimulus(FIPS_KEY);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      rk_idx = 4'd1;
      @(posedge clk);
      #1;
      checkOutput("abort_busy", 128'(busy), 128'(0));
      checkOutput("abort_key_ready", 128'(key_ready), 128'(0));
      checkOutput("abort_rk_out", rk_out, '0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_rk1_cleared", rk_out, '0);
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (key_ready !== 1'b0 || busy !== 1'b0 || rk_out !== '0) bad++;
      end
      checkOutput("abort_stays_idle", 128'(bad), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end

endmodule
